// File: rtl/key_pkg.sv
// Shared definitions for the stopwatch key path: FSM encoding and default hold timings.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } key_state_e;

    // 1 s long-press threshold and 200 ms repeat period at 50 MHz.
    localparam int unsigned DEFAULT_LONG_CYCLES   = 50_000_000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES = 10_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_event.sv
// Turns a debounced key level into registered press/release/short/long/repeat pulses.
module key_event
    import key_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    generate
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("key_event: LONG_CYCLES must be at least 2");
        end
        if (REPEAT_CYCLES < 2) begin : g_bad_repeat
            $error("key_event: REPEAT_CYCLES must be at least 2");
        end
    endgenerate

    logic sync_level;
    logic p;

    // Reset the synchroniser to the released level so reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key_in),
        .q_o   (sync_level)
    );

    assign p = sync_level ^ ACTIVE_LOW;

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (p) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                // A release on the threshold edge wins: it is reported as short.
                if (!p) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!p) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign key_held      = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: active-low and active-high instances against a timing scoreboard.
module tb_key_event;

    localparam int LC = 10;
    localparam int RC = 4;

    logic clk;
    logic rst_n;
    logic key0, key1;
    logic held0, press0, rel0, short0, long0, rep0;
    logic held1, press1, rel1, short1, long1, rep1;

    int n_vec  = 0;
    int n_fail = 0;
    string phase = "init";

    logic [5:0] exp0_q[$];
    logic [5:0] exp1_q[$];

    key_event #(.ACTIVE_LOW(1'b1), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_in(key0),
        .key_held(held0), .press_pulse(press0), .release_pulse(rel0),
        .short_pulse(short0), .long_pulse(long0), .repeat_pulse(rep0)
    );

    key_event #(.ACTIVE_LOW(1'b0), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key1),
        .key_held(held1), .press_pulse(press1), .release_pulse(rel1),
        .short_pulse(short1), .long_pulse(long1), .repeat_pulse(rep1)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Expected {held, press, release, short, long, repeat} at edge N+t for a key
    // pressed before edge N and held for h edges, derived from the documented latencies.
    function automatic logic [5:0] model(input int t, input int h);
        logic held, pr, rl, sh, lg, rp;
        held = (t >= 2) && (t < h + 2);
        pr   = (t == 2);
        rl   = (t == h + 2);
        sh   = rl && (h <= LC);
        lg   = (h > LC) && (t == LC + 2);
        rp   = (h > LC) && (t > LC + 2) && (t < h + 2) && (((t - LC - 2) % RC) == 0);
        return {held, pr, rl, sh, lg, rp};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%b expected=%b (held,press,rel,short,long,rep)",
                   phase, tag, obs, exp);
        end
    endtask

    task automatic tick(input logic k0, input logic k1);
        key0 = k0;
        key1 = k1;
        @(posedge clk);
        #1;
        if (exp0_q.size() > 0)
            check("dut0", {held0, press0, rel0, short0, long0, rep0}, exp0_q.pop_front());
        if (exp1_q.size() > 0)
            check("dut1", {held1, press1, rel1, short1, long1, rep1}, exp1_q.pop_front());
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp0_q.push_back(6'b0);
            exp1_q.push_back(6'b0);
        end
    endtask

    // sel 0 presses the active-low instance, sel 1 the active-high one.
    task automatic run_press(input int sel, input int h, input int total);
        for (int t = 0; t < total; t++) begin
            exp0_q.push_back(sel == 0 ? model(t, h) : 6'b0);
            exp1_q.push_back(sel == 1 ? model(t, h) : 6'b0);
        end
        for (int t = 0; t < total; t++) begin
            if (sel == 0) tick((t < h) ? 1'b0 : 1'b1, 1'b0);
            else          tick(1'b1, (t < h) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        key0  = 1'b1;
        key1  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        phase = "reset";
        check("async0", {held0, press0, rel0, short0, long0, rep0}, 6'b0);
        check("async1", {held1, press1, rel1, short1, long1, rep1}, 6'b0);
        push_idle(3);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        rst_n = 1'b1;

        phase = "idle";
        push_idle(20);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);

        phase = "short";
        run_press(0, 5, 10);

        phase = "long_repeat";
        run_press(0, 30, 36);

        phase = "collision";
        run_press(0, LC, LC + 6);

        phase = "below_threshold";
        run_press(0, LC - 1, LC + 5);

        phase = "mid_hold_reset";
        for (int t = 0; t < 6; t++) begin
            exp0_q.push_back(model(t, 1000));
            exp1_q.push_back(6'b0);
        end
        for (int t = 0; t < 6; t++) tick(1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1 check("async_drop", {held0, press0, rel0, short0, long0, rep0}, 6'b0);
        push_idle(2);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
        rst_n = 1'b1;

        phase = "repress_after_reset";
        run_press(0, 4, 9);

        phase = "polarity";
        run_press(1, 5, 10);

        phase = "polarity_long";
        run_press(1, 15, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Converts the debounced level of one stopwatch push-button into single-cycle event pulses: press, release, short press, long press and auto-repeat. It sits directly behind the key debouncer, on the same 50 MHz clock, and feeds the stopwatch control FSM. Typical use: short press for start/stop, long press for clear, repeat for fast time-setting. It resynchronises its input, so a debouncer on a different timing base can drive it safely.

## Interface
- `ACTIVE_LOW`, default 1: 1 means a pressed key reads 0 on `key_in` (board keys pull low).
- `LONG_CYCLES`, default 50_000_000: hold time, in clocks after the press event, before `long_pulse` fires (1 s). Must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of `repeat_pulse` after the long press (200 ms). Must be ≥ 2.
- `clk` input 1: system clock, 50 MHz (20 ns). All state changes on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `key_in` input 1: debounced key level. Asynchronous to `clk`.
- `key_held` output 1: high while the FSM is not in IDLE.
- `press_pulse` output 1: one-cycle pulse on press.
- `release_pulse` output 1: one-cycle pulse on any release.
- `short_pulse` output 1: one-cycle pulse on a release that happens before the long threshold.
- `long_pulse` output 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` output 1: one-cycle pulse every `REPEAT_CYCLES` while the key is held after the long press.

## Operation
- `key_in` passes through a 2-flop synchroniser, then polarity correction: `p` = `sync2 ^ ACTIVE_LOW`. `p` = 1 means pressed.
- FSM states are IDLE, PRESSED and REPEAT. There is one counter `cnt`, width `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`.
- IDLE, `p`=1: go to PRESSED. `cnt`←0, `press_pulse`=1.
- PRESSED, `p`=1, `cnt`≠LONG_CYCLES−1: `cnt`++.
- PRESSED, `p`=1, `cnt`=LONG_CYCLES−1: go to REPEAT. `cnt`←0, `long_pulse`=1.
- PRESSED, `p`=0: go to IDLE. `cnt`←0, `release_pulse`=1, `short_pulse`=1.
- REPEAT, `p`=1: `cnt`++. When `cnt`=REPEAT_CYCLES−1, set `cnt`←0 and `repeat_pulse`=1. The counter wraps, so pulses continue indefinitely.
- REPEAT, `p`=0: go to IDLE. `cnt`←0, `release_pulse`=1, no `short_pulse`.
- Simultaneous events:
  - Release wins over threshold. If `p`=0 on the edge where `cnt` would hit LONG_CYCLES−1 or REPEAT_CYCLES−1, no long or repeat pulse is produced.
  - A release is reported as short only if it occurs in PRESSED.
- At most one of `press_pulse`, `long_pulse`, `repeat_pulse` and `release_pulse` is high in any cycle. `short_pulse` is only ever high together with `release_pulse`.
- All pulse outputs and `key_held` are registered. No combinational path from `key_in` to any output.

## Timing
- Reset (`rst_n`=0), immediately and asynchronously:
  - State = IDLE, `cnt` = 0.
  - Synchroniser flops = unpressed level (1 if `ACTIVE_LOW`).
  - All outputs = 0.
- Reset release while the key is held: the key is seen as a fresh press, so `press_pulse` fires after the normal latency.
- Reset mid-hold aborts the hold with no `release_pulse`.
- Press latency: `key_in` goes to the pressed level before rising edge N. The synchroniser captures it at N and N+1. `press_pulse` and `key_held` go high after edge N+2, so `press_pulse` is high for the cycle N+2..N+3. Release latency is identical.
- `long_pulse` is asserted exactly `LONG_CYCLES` cycles after `press_pulse`.
- First `repeat_pulse` comes `REPEAT_CYCLES` cycles after `long_pulse`, then one every `REPEAT_CYCLES` cycles.
- Presses shorter than 1 clock can be missed. That is acceptable because the input is already debounced.

## Structure
- Shared `key_pkg` holds:
  - FSM state encoding (IDLE=2'd0, PRESSED=2'd1, REPEAT=2'd2). Unused encoding 2'd3 recovers to IDLE.
  - Default `LONG_CYCLES` / `REPEAT_CYCLES` constants, shared with the stopwatch top.
- Sub-module `sync_2ff`: a 2-flop synchroniser with a reset value parameter. It is reused for the other stopwatch keys.
- Elaboration-time check rejects `LONG_CYCLES` < 2 and `REPEAT_CYCLES` < 2.

## Test plan
Bench parameters: `LONG_CYCLES`=10, `REPEAT_CYCLES`=4, `ACTIVE_LOW`=1.
- Reset then idle: hold `rst_n`=0 for 3 cycles, release it, keep `key_in`=1 for 20 cycles → all outputs 0 throughout.
- Short press: drive `key_in`=0 before edge N, hold 5 cycles, then 1.
  - `press_pulse` high in the cycle after edge N+2.
  - `release_pulse` and `short_pulse` high together, exactly 5 cycles later.
  - No `long_pulse`.
- Long press with repeat: hold `key_in`=0 for 30 cycles.
  - `long_pulse` exactly 10 cycles after `press_pulse`.
  - `repeat_pulse` at +4, +8, +12 and +16 after `long_pulse`.
  - On release: `release_pulse` high, `short_pulse` stays 0.
- Threshold collision: release so that `p` falls on the same edge as the 10th count → `release_pulse` and `short_pulse` fire, `long_pulse` never asserted.
- Reset mid-hold: assert `rst_n`=0 at cycle 6 of a hold → outputs drop to 0 at once, no `release_pulse`. Deassert `rst_n` with the key still held → new `press_pulse` 3 edges later.
- Polarity: with `ACTIVE_LOW`=0, repeat the short press using `key_in`=1 → same pulse pattern and latency.
